// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU memory stage and a host/loader port
//   clk, reset                  clock and synchronous active-high reset
//   cpu_req/we/addr/wdata       processor access; cpu_stall freezes the pipeline when not granted
//   cpu_rvalid/cpu_rdata        processor read return, one cycle after an accepted read
//   host_req/we/lock/addr/wdata host access; host_lock asks for back-to-back grants
//   host_gnt/rvalid/rdata       host grant and read return
//   mem_en/we/addr/wdata/rdata  memory side; mem_rdata is valid the cycle after the address
//   stall_cnt                   saturating count of processor stall cycles
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int HOST_BURST = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int BW = $clog2(HOST_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(HOST_BURST);
  logic              last_host_q, last_host_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              tag_vld_q, tag_vld_d, tag_host_q, tag_host_d;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              cpu_gnt, host_win;
  // On a tie the host wins if it holds a burst with budget left, or if the CPU was served last
  always_comb begin
    host_win  = (host_lock && burst_q < BURST_MAX) || !last_host_q;
    host_gnt  = !reset && host_req && (!cpu_req || host_win);
    cpu_gnt   = !reset && cpu_req && !host_gnt;
    cpu_stall = !reset && cpu_req && !cpu_gnt;
    mem_en    = cpu_gnt || host_gnt;
    mem_we    = host_gnt ? host_we : cpu_gnt && cpu_we;
    mem_addr  = host_gnt ? host_addr : cpu_gnt ? cpu_addr : '0;
    mem_wdata = host_gnt ? host_wdata : cpu_gnt ? cpu_wdata : '0;
  end
  // Read return is steered by the tag; the idle side keeps showing its last returned word
  always_comb begin
    cpu_rvalid  = !reset && tag_vld_q && !tag_host_q;
    host_rvalid = !reset && tag_vld_q && tag_host_q;
    cpu_rdata   = reset ? '0 : cpu_rvalid ? mem_rdata : cpu_rdata_q;
    host_rdata  = reset ? '0 : host_rvalid ? mem_rdata : host_rdata_q;
    stall_cnt   = reset ? '0 : stall_cnt_q;
  end
  // Burst budget only runs while the CPU is actually waiting
  always_comb begin
    last_host_d = host_gnt || (last_host_q && !cpu_gnt);
    burst_d     = (cpu_gnt || !cpu_req) ? '0 : host_gnt ? burst_q + 1'b1 : burst_q;
    tag_vld_d   = (host_gnt && !host_we) || (cpu_gnt && !cpu_we);
    tag_host_d  = host_gnt;
    stall_cnt_d = (cpu_stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_host_q  <= 1'b1;
      burst_q      <= '0;
      tag_vld_q    <= 1'b0;
      tag_host_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      last_host_q  <= last_host_d;
      burst_q      <= burst_d;
      tag_vld_q    <= tag_vld_d;
      tag_host_q   <= tag_host_d;
      cpu_rdata_q  <= cpu_rdata;
      host_rdata_q <= host_rdata;
      stall_cnt_q  <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven check of dmem_arbiter plus a stall-counter saturation sequence
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset, cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata, mem_rdata;
  logic        cpu_stall, cpu_rvalid, host_gnt, host_rvalid, mem_en, mem_we;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
  logic [15:0] stall_cnt;
  logic        s_stall, s_crv, s_hgnt, s_hrv, s_men, s_mwe;
  logic [31:0] s_crd, s_hrd, s_maddr, s_mwd;
  logic [3:0]  s_cnt;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );
  dmem_arbiter #(.HOST_BURST(32), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(s_stall), .cpu_rvalid(s_crv), .cpu_rdata(s_crd),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(s_hgnt), .host_rvalid(s_hrv), .host_rdata(s_hrd),
    .mem_en(s_men), .mem_we(s_mwe), .mem_addr(s_maddr), .mem_wdata(s_mwd),
    .mem_rdata(mem_rdata), .stall_cnt(s_cnt)
  );
  typedef struct packed {
    logic        rst, creq, cwe;
    logic [31:0] caddr, cwd;
    logic        hreq, hwe, hlock;
    logic [31:0] haddr, hwd, mrd;
    logic        stall, hgnt, men, mwe;
    logic [31:0] maddr, mwd;
    logic        crv;
    logic [31:0] crd;
    logic        hrv;
    logic [31:0] hrd;
    logic [15:0] scnt;
  } vec_t;
  vec_t vt [21];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic hr, input logic hw, input logic hl, input logic [31:0] ha, input logic [31:0] hd,
                       input logic [31:0] md);
    reset = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd; mem_rdata = md;
  endtask
  initial begin
    // rst creq cwe caddr cwd | hreq hwe hlock haddr hwd | mrd | stall hgnt men mwe maddr mwd | crv crd hrv hrd scnt
    vt[0]  = '{1'b1,1'b1,1'b0,32'h40,32'h0, 1'b1,1'b0,1'b0,32'h20,32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,1'b0,32'h0,16'd0};
    vt[1]  = '{1'b0,1'b1,1'b0,32'h40,32'h11111111, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'h0, 1'b0,1'b0,1'b1,1'b0,32'h40,32'h11111111, 1'b0,32'h0,1'b0,32'h0,16'd0};
    vt[2]  = '{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b1,32'hDEADBEEF,1'b0,32'h0,16'd0};
    vt[3]  = '{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'h12345678, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'hDEADBEEF,1'b0,32'h0,16'd0};
    vt[4]  = '{1'b1,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,1'b0,32'h0,16'd0};
    vt[5]  = '{1'b0,1'b1,1'b0,32'h10,32'h0, 1'b1,1'b0,1'b0,32'h20,32'h0, 32'h0, 1'b0,1'b0,1'b1,1'b0,32'h10,32'h0, 1'b0,32'h0,1'b0,32'h0,16'd0};
    vt[6]  = '{1'b0,1'b1,1'b0,32'h14,32'h0, 1'b1,1'b0,1'b0,32'h20,32'h0, 32'hAAAA0010, 1'b1,1'b1,1'b1,1'b0,32'h20,32'h0, 1'b1,32'hAAAA0010,1'b0,32'h0,16'd0};
    vt[7]  = '{1'b0,1'b1,1'b0,32'h14,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'hBBBB0020, 1'b0,1'b0,1'b1,1'b0,32'h14,32'h0, 1'b0,32'hAAAA0010,1'b1,32'hBBBB0020,16'd1};
    vt[8]  = '{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'hCCCC0014, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b1,32'hCCCC0014,1'b0,32'hBBBB0020,16'd1};
    vt[9]  = '{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0,32'h80,32'hCAFEF00D, 32'h0, 1'b0,1'b1,1'b1,1'b1,32'h80,32'hCAFEF00D, 1'b0,32'hCCCC0014,1'b0,32'hBBBB0020,16'd1};
    vt[10] = '{1'b0,1'b1,1'b1,32'h44,32'h0BADF00D, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'hFFFFFFFF, 1'b0,1'b0,1'b1,1'b1,32'h44,32'h0BADF00D, 1'b0,32'hCCCC0014,1'b0,32'hBBBB0020,16'd1};
    vt[11] = '{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'hFFFFFFFF, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'hCCCC0014,1'b0,32'hBBBB0020,16'd1};
    vt[12] = '{1'b1,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,1'b0,32'h0,16'd0};
    vt[13] = '{1'b0,1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b1,32'h200,32'h0, 32'h0, 1'b1,1'b1,1'b1,1'b0,32'h200,32'h0, 1'b0,32'h0,1'b0,32'h0,16'd0};
    vt[14] = '{1'b0,1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b1,32'h200,32'h0, 32'h14, 1'b1,1'b1,1'b1,1'b0,32'h200,32'h0, 1'b0,32'h0,1'b1,32'h14,16'd1};
    vt[15] = '{1'b0,1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b1,32'h200,32'h0, 32'h15, 1'b1,1'b1,1'b1,1'b0,32'h200,32'h0, 1'b0,32'h0,1'b1,32'h15,16'd2};
    vt[16] = '{1'b0,1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b1,32'h200,32'h0, 32'h16, 1'b1,1'b1,1'b1,1'b0,32'h200,32'h0, 1'b0,32'h0,1'b1,32'h16,16'd3};
    vt[17] = '{1'b0,1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b1,32'h200,32'h0, 32'h17, 1'b0,1'b0,1'b1,1'b0,32'h100,32'h0, 1'b0,32'h0,1'b1,32'h17,16'd4};
    vt[18] = '{1'b0,1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b1,32'h200,32'h0, 32'h18, 1'b1,1'b1,1'b1,1'b0,32'h200,32'h0, 1'b1,32'h18,1'b0,32'h17,16'd4};
    vt[19] = '{1'b1,1'b1,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b1,32'h200,32'h0, 32'h19, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,1'b0,32'h0,16'd0};
    vt[20] = '{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 32'h55, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,1'b0,32'h0,16'd0};
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].cwd,
            vt[i].hreq, vt[i].hwe, vt[i].hlock, vt[i].haddr, vt[i].hwd, vt[i].mrd);
      #1;
      n_vec++;
      chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(vt[i].stall));
      chk($sformatf("v%0d host_gnt", i), 32'(host_gnt), 32'(vt[i].hgnt));
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vt[i].men));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vt[i].mwe));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].maddr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].mwd);
      chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vt[i].crv));
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].crd);
      chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 32'(vt[i].hrv));
      chk($sformatf("v%0d host_rdata", i), host_rdata, vt[i].hrd);
      chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vt[i].scnt));
      chk($sformatf("v%0d both_rvalid", i), 32'(cpu_rvalid && host_rvalid), 32'h0);
    end
    // CPU held off by a long locked host burst: 4-bit counter must stop at 15
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++;
      chk($sformatf("sat%0d cpu_stall", k), 32'(s_stall), 32'h1);
      chk($sformatf("sat%0d stall_cnt", k), 32'(s_cnt), (k > 15) ? 32'd15 : 32'(k));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    n_vec++;
    chk("sat_final stall_cnt", 32'(s_cnt), 32'd15);
    chk("sat_final cpu_stall", 32'(s_stall), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
